sr_drive_ctrl: RTL and testbench

Upstream command stage that drives the `s`/`r` inputs of the team's SR flip-flop from two raw, asynchronous request lines, `set_req` and `clr_req`. It synchronizes and debounces each line and turns each debounced rising edge into a fixed-width `s` or `r` pulse. It guarantees that `s` and `r` are never high together, so the flip-flop's illegal 11 state is unreachable. Conflicting requests are dropped, flagged and counted.

---
 rtl/sr_drive_ctrl.sv | 159 +++++++++++++++
 tb/tb_sr_drive_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl
// Command stage in front of an SR flip-flop. Two raw, asynchronous request
// lines are synchronized, debounced and edge-detected; each debounced rising
// edge becomes a PULSE_W-cycle pulse on s or r. The pulses come from one FSM
// whose states are mutually exclusive, so s and r are never high together.
// Requests that arrive on both lines in the same cycle are dropped, flagged
// on conflict and counted.
//
// Ports
//   clk          : single clock, all registers rising-edge
//   resetn       : asynchronous active-low reset
//   set_req      : raw set request (asynchronous)
//   clr_req      : raw clear request (asynchronous)
//   s            : registered set pulse
//   r            : registered reset pulse
//   busy         : FSM not in IDLE
//   conflict     : one-cycle flag for a dropped simultaneous request
//   conflict_cnt : saturating count of conflicts
module sr_drive_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int PULSE_W   = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             set_req,
  input  logic             clr_req,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  // dcnt only ever holds 0..DB_CYCLES-1; reaching DB_LAST and still differing
  // is the cycle on which the increment would hit DB_CYCLES.
  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
  localparam int WW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(PULSE_W - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2,
    GAP     = 2'd3
  } state_t;

  // Bit 0 is the set channel, bit 1 the clear channel.
  logic [1:0]    sync1, sync2, db, db_q;
  logic [DW-1:0] dcnt [2];

  state_t        state, state_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic          pend_s, pend_r, pend_s_n, pend_r_n;
  logic          set_ev, clr_ev, conflict_n;

  // Synchronizers, debounce and the delayed level for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < 2; i++) dcnt[i] <= '0;
    end else begin
      sync1 <= {clr_req, set_req};
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DB_LAST) begin
          db[i]   <= ~db[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  assign set_ev     = db[0] & ~db_q[0];
  assign clr_ev     = db[1] & ~db_q[1];
  assign conflict_n = set_ev & clr_ev;

  always_comb begin
    state_n  = state;
    wcnt_n   = wcnt;
    pend_s_n = pend_s;
    pend_r_n = pend_r;

    case (state)
      IDLE: begin
        if (pend_s) begin
          state_n  = PULSE_S;
          wcnt_n   = '0;
          pend_s_n = 1'b0;
        end else if (pend_r) begin
          state_n  = PULSE_R;
          wcnt_n   = '0;
          pend_r_n = 1'b0;
        end
      end
      PULSE_S, PULSE_R: begin
        if (wcnt == W_LAST) state_n = GAP;
        else                wcnt_n  = wcnt + WW'(1);
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // New events are applied after IDLE has consumed a pending flag, so an
    // event in the same cycle still leaves its own request pending. The latest
    // single event wins; an event repeating the pulse already on the wire is
    // redundant and dropped.
    if (conflict_n) begin
      pend_s_n = pend_s;
      pend_r_n = pend_r;
      if (state == IDLE) begin
        pend_s_n = pend_s ? 1'b0 : pend_s;
        pend_r_n = (!pend_s && pend_r) ? 1'b0 : pend_r;
      end
    end else if (set_ev && state != PULSE_S) begin
      pend_s_n = 1'b1;
      pend_r_n = 1'b0;
    end else if (clr_ev && state != PULSE_R) begin
      pend_r_n = 1'b1;
      pend_s_n = 1'b0;
    end
  end

  // Outputs are registered from the next state so they switch cleanly with it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      wcnt         <= '0;
      pend_s       <= 1'b0;
      pend_r       <= 1'b0;
      s            <= 1'b0;
      r            <= 1'b0;
      busy         <= 1'b0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      state    <= state_n;
      wcnt     <= wcnt_n;
      pend_s   <= pend_s_n;
      pend_r   <= pend_r_n;
      s        <= (state_n == PULSE_S);
      r        <= (state_n == PULSE_R);
      busy     <= (state_n != IDLE);
      conflict <= conflict_n;
      if (conflict_n && (conflict_cnt != {CNT_W{1'b1}}))
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Testbench for sr_drive_ctrl. Two instances share the request lines:
// dut_a uses the default parameters, dut_b uses a short debounce, long pulse
// and a 2-bit counter. Every cycle both are compared with a behavioural model
// that tracks pulses as countdowns; hand-derived tables and sequences pin the
// exact timing of the main scenarios.
module tb_sr_drive_ctrl;

  localparam int A_DB = 4, A_PW = 2, A_CW = 8;
  localparam int B_DB = 2, B_PW = 8, B_CW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;
  always #5 clk = ~clk;

  logic            s_a, r_a, busy_a, conflict_a;
  logic [A_CW-1:0] cnt_a;
  logic            s_b, r_b, busy_b, conflict_b;
  logic [B_CW-1:0] cnt_b;

  sr_drive_ctrl #(.DB_CYCLES(A_DB), .PULSE_W(A_PW), .CNT_W(A_CW)) dut_a (
    .clk(clk), .resetn(resetn), .set_req(set_req), .clr_req(clr_req),
    .s(s_a), .r(r_a), .busy(busy_a), .conflict(conflict_a), .conflict_cnt(cnt_a)
  );

  sr_drive_ctrl #(.DB_CYCLES(B_DB), .PULSE_W(B_PW), .CNT_W(B_CW)) dut_b (
    .clk(clk), .resetn(resetn), .set_req(set_req), .clr_req(clr_req),
    .s(s_b), .r(r_b), .busy(busy_b), .conflict(conflict_b), .conflict_cnt(cnt_b)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit [1:0]       sy1, sy2, db, dbq;
    bit [1:0][15:0] run;
    bit             pend_s, pend_r;
    int             s_left, r_left, gap_left;
    bit             conflict;
    int             cnt;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_reset();
    model_t m;
    m.sy1 = '0; m.sy2 = '0; m.db = '0; m.dbq = '0; m.run = '0;
    m.pend_s = 0; m.pend_r = 0;
    m.s_left = 0; m.r_left = 0; m.gap_left = 0;
    m.conflict = 0; m.cnt = 0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, bit sreq, bit creq,
                                        int dbc, int pw, int cw);
    model_t n;
    bit ev_s, ev_r, idle, start_s, start_r;
    n       = m;
    ev_s    = m.db[0] & ~m.dbq[0];
    ev_r    = m.db[1] & ~m.dbq[1];
    idle    = (m.s_left == 0) && (m.r_left == 0) && (m.gap_left == 0);
    start_s = 0;
    start_r = 0;
    n.sy1 = {creq, sreq};
    n.sy2 = m.sy1;
    n.dbq = m.db;
    for (int ch = 0; ch < 2; ch++) begin
      if (m.sy2[ch] == m.db[ch]) n.run[ch] = 0;
      else if (int'(m.run[ch]) + 1 >= dbc) begin
        n.db[ch]  = ~m.db[ch];
        n.run[ch] = 0;
      end else n.run[ch] = m.run[ch] + 16'd1;
    end
    if (idle) begin
      if (m.pend_s) begin start_s = 1; n.pend_s = 0; end
      else if (m.pend_r) begin start_r = 1; n.pend_r = 0; end
    end
    n.conflict = ev_s && ev_r;
    if (ev_s && ev_r) begin
      if (m.cnt < (1 << cw) - 1) n.cnt = m.cnt + 1;
    end else if (ev_s) begin
      if (m.s_left == 0) begin n.pend_s = 1; n.pend_r = 0; end
    end else if (ev_r) begin
      if (m.r_left == 0) begin n.pend_r = 1; n.pend_s = 0; end
    end
    if (m.s_left > 0) begin
      n.s_left = m.s_left - 1;
      if (n.s_left == 0) n.gap_left = 1;
    end else if (m.r_left > 0) begin
      n.r_left = m.r_left - 1;
      if (n.r_left == 0) n.gap_left = 1;
    end else if (m.gap_left > 0) n.gap_left = 0;
    else if (start_s) n.s_left = pw;
    else if (start_r) n.r_left = pw;
    return n;
  endfunction

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_models();
    chk("model_s_a",    s_a,        ma.s_left > 0);
    chk("model_r_a",    r_a,        ma.r_left > 0);
    chk("model_busy_a", busy_a,     (ma.s_left + ma.r_left + ma.gap_left) > 0);
    chk("model_conf_a", conflict_a, ma.conflict);
    chk("model_cnt_a",  cnt_a,      ma.cnt);
    chk("model_s_b",    s_b,        mb.s_left > 0);
    chk("model_r_b",    r_b,        mb.r_left > 0);
    chk("model_busy_b", busy_b,     (mb.s_left + mb.r_left + mb.gap_left) > 0);
    chk("model_conf_b", conflict_b, mb.conflict);
    chk("model_cnt_b",  cnt_b,      mb.cnt);
  endtask

  // ---------------- driver ----------------
  // Drive inputs, take one rising edge, advance the models, sample 1 ns later.
  task automatic step_cycle(input logic sreq, input logic creq);
    set_req = sreq;
    clr_req = creq;
    @(posedge clk);
    if (!resetn) begin
      ma = model_reset();
      mb = model_reset();
    end else begin
      ma = model_step(ma, sreq, creq, A_DB, A_PW, A_CW);
      mb = model_step(mb, sreq, creq, B_DB, B_PW, B_CW);
    end
    #1;
    check_models();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step_cycle(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    ma = model_reset();
    mb = model_reset();
    idle_cycles(2);
    resetn = 1'b1;
    idle_cycles(3);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic set_req, clr_req;
    logic s, r, busy, conflict;
    int   cnt;
  } vec_t;

  localparam int TBL_N = 61;
  vec_t tbl [TBL_N];

  initial begin
    bit seen;
    int hold;
    logic sr, cr;

    // Row i is driven before edge i and checked after it (dut_a, defaults).
    // Rows 0-14: single set; 25-35: simultaneous rise; 48-50: 3-cycle glitch.
    for (int i = 0; i < TBL_N; i++) begin
      tbl[i].set_req  = (i < 15) || (i >= 25 && i < 36) || (i >= 48 && i < 51);
      tbl[i].clr_req  = (i >= 25 && i < 36);
      tbl[i].s        = (i == 7) || (i == 8);
      tbl[i].r        = 1'b0;
      tbl[i].busy     = (i >= 7 && i <= 9);
      tbl[i].conflict = (i == 31);
      tbl[i].cnt      = (i >= 31) ? 1 : 0;
    end

    ma = model_reset();
    mb = model_reset();

    // Reset values
    resetn = 1'b0;
    idle_cycles(2);
    chk("rst_s", s_a, 0);
    chk("rst_r", r_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_conflict", conflict_a, 0);
    chk("rst_cnt", cnt_a, 0);
    resetn = 1'b1;
    idle_cycles(3);

    // Table: single set, release, simultaneous, glitch
    for (int i = 0; i < TBL_N; i++) begin
      step_cycle(tbl[i].set_req, tbl[i].clr_req);
      chk($sformatf("tbl%0d_s", i),        s_a,        tbl[i].s);
      chk($sformatf("tbl%0d_r", i),        r_a,        tbl[i].r);
      chk($sformatf("tbl%0d_busy", i),     busy_a,     tbl[i].busy);
      chk($sformatf("tbl%0d_conflict", i), conflict_a, tbl[i].conflict);
      chk($sformatf("tbl%0d_cnt", i),      cnt_a,      tbl[i].cnt);
    end
    idle_cycles(30);

    // Set then clear back-to-back: clr debounced while s pulses
    for (int k = 0; k < 21; k++) begin
      step_cycle(1'b1, k >= 2);
      chk($sformatf("b2b%0d_s", k), s_a, (k == 7) || (k == 8));
      chk($sformatf("b2b%0d_r", k), r_a, (k == 11) || (k == 12));
      chk($sformatf("b2b%0d_sr", k), s_a & r_a, 0);
    end
    idle_cycles(40);

    // Latest wins (dut_b): pend_r set during PULSE_S, set_ev lands in GAP
    for (int k = 0; k < 36; k++) begin
      step_cycle((k <= 1) || (k >= 10), k >= 3);
      chk($sformatf("latest%0d_s_b", k), s_b, (k >= 5 && k <= 12) || (k >= 15 && k <= 22));
      chk($sformatf("latest%0d_r_b", k), r_b, 0);
    end
    idle_cycles(40);

    // Asynchronous reset in the middle of PULSE_S
    for (int k = 0; k < 8; k++) step_cycle(1'b1, 1'b0);
    chk("pre_rst_s", s_a, 1);
    set_req = 1'b0;
    resetn  = 1'b0;
    #1;
    chk("async_rst_s", s_a, 0);
    chk("async_rst_r", r_a, 0);
    chk("async_rst_busy", busy_a, 0);
    chk("async_rst_conflict", conflict_a, 0);
    chk("async_rst_cnt", cnt_a, 0);
    chk("async_rst_s_b", s_b, 0);
    chk("async_rst_busy_b", busy_b, 0);
    ma = model_reset();
    mb = model_reset();
    idle_cycles(2);
    resetn = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step_cycle(1'b0, 1'b0);
      seen = seen | s_a | r_a | busy_a;
    end
    chk("post_rst_no_pulse", seen, 0);

    // Conflict counter saturation: 256 simultaneous rises
    do_reset();
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 16; k++) step_cycle(k < 8, k < 8);
      chk($sformatf("sat%0d_a", i), cnt_a, (i + 1 < 255) ? i + 1 : 255);
      chk($sformatf("sat%0d_b", i), cnt_b, (i + 1 < 3) ? i + 1 : 3);
    end
    chk("sat_final_a", cnt_a, 255);

    // Randomized requests against the model
    do_reset();
    hold = 0;
    sr = 1'b0;
    cr = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 2))
          0: sr = ($urandom_range(0, 1) == 1);
          1: cr = ($urandom_range(0, 1) == 1);
          default: begin
            sr = ($urandom_range(0, 1) == 1);
            cr = sr;
          end
        endcase
        hold = $urandom_range(1, 10);
      end
      hold--;
      step_cycle(sr, cr);
      chk("rand_sr_a", s_a & r_a, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
